// File: rtl/m1_ex_reg.sv
// m1_ex_reg: execute-stage output register with a two-entry skid buffer,
// overflow detection at capture and a saturating overflow counter.
module m1_ex_reg #(
    parameter int         TRAP_ON_OVF = 1,
    parameter logic [4:0] ALU_OP_ADD  = 5'd0,
    parameter logic [4:0] ALU_OP_SUB  = 5'd2
) (
    input  logic        sys_clock_i,
    input  logic        sys_reset_i,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [32:0] alu_result_i,
    input  logic        a_msb_i,
    input  logic        b_msb_i,
    input  logic [4:0]  func_i,
    input  logic        signed_i,
    input  logic        trap_en_i,
    input  logic [4:0]  rd_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        carry_o,
    output logic [4:0]  rd_o,
    output logic        we_o,
    output logic        ovf_o,
    output logic [15:0] ovf_count_o
);
    typedef struct packed {
        logic [31:0] result;
        logic        carry;
        logic [4:0]  rd;
        logic        we;
        logic        ovf;
    } entry_t;

    entry_t      main_q, skid_q, in_entry;
    logic        main_valid, skid_valid;
    logic        accept, xfer, add_ovf, sub_ovf, in_ovf;
    logic [15:0] ovf_count;

    assign add_ovf  = func_i == ALU_OP_ADD && a_msb_i == b_msb_i && alu_result_i[31] != a_msb_i;
    assign sub_ovf  = func_i == ALU_OP_SUB && a_msb_i != b_msb_i && alu_result_i[31] != a_msb_i;
    assign in_ovf   = signed_i && trap_en_i && (add_ovf || sub_ovf);
    assign in_entry = '{
        result: alu_result_i[31:0],
        carry:  alu_result_i[32],
        rd:     rd_i,
        we:     rd_i != 5'd0 && !(in_ovf && TRAP_ON_OVF != 0),
        ovf:    in_ovf
    };

    // Ready depends only on registered state so upstream never sees ready_i.
    assign ready_o = !skid_valid;
    assign accept  = valid_i && ready_o && !flush_i;
    assign xfer    = main_valid && ready_i;

    always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
        if (!sys_reset_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (xfer && skid_valid) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
        end else if (accept && (!main_valid || xfer)) begin
            main_q     <= in_entry;
            main_valid <= 1'b1;
        end else if (accept) begin
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
        end else if (xfer) begin
            main_valid <= 1'b0;
        end
    end

    always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
        if (!sys_reset_i)
            ovf_count <= '0;
        else if (accept && in_entry.ovf && ovf_count != 16'hFFFF)
            ovf_count <= ovf_count + 16'd1;
    end

    assign valid_o     = main_valid;
    assign result_o    = main_q.result;
    assign carry_o     = main_q.carry;
    assign rd_o        = main_q.rd;
    assign we_o        = main_valid && main_q.we;
    assign ovf_o       = main_valid && main_q.ovf;
    assign ovf_count_o = ovf_count;
endmodule

// File: tb/tb_m1_ex_reg.sv
// tb_m1_ex_reg: scoreboard bench for m1_ex_reg; a reference occupancy model
// queues expected entries on accept and checks them as they reach the output.
module tb_m1_ex_reg;
    localparam logic [4:0] ADD = 5'd0;
    localparam logic [4:0] SUB = 5'd2;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic [4:0]  rd;
        logic        we;
        logic        ovf;
    } ent_t;

    logic        clk = 1'b0, rst_n = 1'b1, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
    logic [32:0] alu_result_i = '0;
    logic        a_msb_i = 1'b0, b_msb_i = 1'b0, signed_i = 1'b0, trap_en_i = 1'b0;
    logic [4:0]  func_i = '0, rd_i = '0;
    logic        ready_o, valid_o, carry_o, we_o, ovf_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic [15:0] ovf_count_o;

    int checks = 0, fails = 0;
    ent_t q[$];
    logic [1:0]  occ = 2'd0;
    logic [15:0] m_cnt = '0;
    logic        m_acc, m_xfer;

    m1_ex_reg #(.TRAP_ON_OVF(1), .ALU_OP_ADD(ADD), .ALU_OP_SUB(SUB)) dut (
        .sys_clock_i(clk), .sys_reset_i(rst_n), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .alu_result_i(alu_result_i), .a_msb_i(a_msb_i), .b_msb_i(b_msb_i),
        .func_i(func_i), .signed_i(signed_i), .trap_en_i(trap_en_i), .rd_i(rd_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .carry_o(carry_o),
        .rd_o(rd_o), .we_o(we_o), .ovf_o(ovf_o), .ovf_count_o(ovf_count_o)
    );

    always #5 clk = ~clk;

    function automatic ent_t exp_entry();
        logic ov;
        ov = signed_i && trap_en_i &&
             ((func_i == ADD && a_msb_i == b_msb_i && alu_result_i[31] != a_msb_i) ||
              (func_i == SUB && a_msb_i != b_msb_i && alu_result_i[31] != a_msb_i));
        return '{alu_result_i[31:0], alu_result_i[32], rd_i, rd_i != 5'd0 && !ov, ov};
    endfunction

    // Reference model: two-slot occupancy plus expected-entry queue.
    assign m_acc  = valid_i && occ != 2'd2 && !flush_i;
    assign m_xfer = occ != 2'd0 && ready_i;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ   <= 2'd0;
            m_cnt <= '0;
            q.delete();
        end else if (flush_i) begin
            occ <= 2'd0;
            q.delete();
        end else begin
            if (m_xfer) void'(q.pop_front());
            if (m_acc) q.push_back(exp_entry());
            occ <= occ - {1'b0, m_xfer} + {1'b0, m_acc};
            if (m_acc && exp_entry().ovf && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (valid_o !== (occ != 2'd0) || ready_o !== (occ != 2'd2)) begin
                fails++;
                $display("FAIL handshake: valid_o=%b ready_o=%b want occ=%0d", valid_o, ready_o, occ);
            end
            checks++;
            if (ovf_count_o !== m_cnt) begin
                fails++;
                $display("FAIL ovf_count: got %h want %h", ovf_count_o, m_cnt);
            end
            checks++;
            if (occ != 2'd0) begin
                if ({result_o, carry_o, rd_o, we_o, ovf_o} !== q[0]) begin
                    fails++;
                    $display("FAIL entry: got %h want %h", {result_o, carry_o, rd_o, we_o, ovf_o}, q[0]);
                end
            end else if (we_o !== 1'b0 || ovf_o !== 1'b0) begin
                fails++;
                $display("FAIL idle_flags: we_o=%b ovf_o=%b want 0", we_o, ovf_o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [32:0] r, input logic a, input logic b,
                         input logic [4:0] f, input logic s, input logic t, input logic [4:0] d);
        valid_i = v; alu_result_i = r; a_msb_i = a; b_msb_i = b;
        func_i = f; signed_i = s; trap_en_i = t; rd_i = d;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'd0 || carry_o !== 1'b0 ||
            rd_o !== 5'd0 || we_o !== 1'b0 || ovf_o !== 1'b0 || ovf_count_o !== 16'd0) begin
            fails++;
            $display("FAIL reset: got rdy=%b v=%b res=%h c=%b rd=%h we=%b ovf=%b cnt=%h want 1 0 0 0 0 0 0 0",
                     ready_o, valid_o, result_o, carry_o, rd_o, we_o, ovf_o, ovf_count_o);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_add_ovf();
        ready_i = 1'b1;
        drive(1, 33'h0_8000_0000, 0, 0, ADD, 1, 1, 5'd5);
        step();
        drive(0, '0, 0, 0, ADD, 0, 0, 5'd0);
        checks++;
        if (valid_o !== 1'b1 || ovf_o !== 1'b1 || we_o !== 1'b0 || ovf_count_o !== 16'd1) begin
            fails++;
            $display("FAIL add_ovf: got v=%b ovf=%b we=%b cnt=%0d want 1 1 0 1", valid_o, ovf_o, we_o, ovf_count_o);
        end
        step();
    endtask

    task automatic test_addu();
        drive(1, 33'h0_8000_0000, 0, 0, ADD, 0, 0, 5'd0);
        step();
        drive(0, '0, 0, 0, ADD, 0, 0, 5'd0);
        checks++;
        if (valid_o !== 1'b1 || ovf_o !== 1'b0 || we_o !== 1'b0 || result_o !== 32'h8000_0000) begin
            fails++;
            $display("FAIL addu: got v=%b ovf=%b we=%b res=%h want 1 0 0 80000000", valid_o, ovf_o, we_o, result_o);
        end
        step();
    endtask

    task automatic test_sub_and_write();
        drive(1, 33'h0_9000_0000, 0, 1, SUB, 1, 1, 5'd3);
        step();
        drive(1, 33'h1_0000_0001, 1, 0, ADD, 1, 1, 5'd7);
        checks++;
        if (ovf_o !== 1'b1 || we_o !== 1'b0 || ovf_count_o !== 16'd2) begin
            fails++;
            $display("FAIL sub_ovf: got ovf=%b we=%b cnt=%0d want 1 0 2", ovf_o, we_o, ovf_count_o);
        end
        step();
        drive(0, '0, 0, 0, ADD, 0, 0, 5'd0);
        checks++;
        if (ovf_o !== 1'b0 || we_o !== 1'b1 || rd_o !== 5'd7 || carry_o !== 1'b1 || result_o !== 32'd1) begin
            fails++;
            $display("FAIL add_write: got ovf=%b we=%b rd=%0d c=%b res=%h want 0 1 7 1 1",
                     ovf_o, we_o, rd_o, carry_o, result_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b0;
        drive(1, 33'd1, 0, 0, ADD, 0, 0, 5'd1);
        step();
        drive(1, 33'd2, 0, 0, ADD, 0, 0, 5'd2);
        step();
        drive(1, 33'd3, 0, 0, ADD, 0, 0, 5'd3);
        step();
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || result_o !== 32'd1) begin
            fails++;
            $display("FAIL bp_full: got rdy=%b v=%b res=%0d want 0 1 1", ready_o, valid_o, result_o);
        end
        drive(0, '0, 0, 0, ADD, 0, 0, 5'd0);
        ready_i = 1'b1;
        step();
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b1 || result_o !== 32'd2) begin
            fails++;
            $display("FAIL bp_drain: got rdy=%b v=%b res=%0d want 1 1 2", ready_o, valid_o, result_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_empty: got v=%b want 0", valid_o);
        end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        drive(1, 33'd10, 0, 0, ADD, 0, 0, 5'd4);
        step();
        drive(1, 33'd11, 0, 0, ADD, 0, 0, 5'd4);
        step();
        drive(1, 33'h0_8000_0000, 0, 0, ADD, 1, 1, 5'd5);
        ready_i = 1'b1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        drive(0, '0, 0, 0, ADD, 0, 0, 5'd0);
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || ovf_count_o !== 16'd2) begin
            fails++;
            $display("FAIL flush: got v=%b rdy=%b cnt=%0d want 0 1 2", valid_o, ready_o, ovf_count_o);
        end
        step();
    endtask

    task automatic test_saturate();
        int n = 0;
        ready_i = 1'b1;
        drive(1, 33'h0_8000_0000, 0, 0, ADD, 1, 1, 5'd9);
        while (m_cnt != 16'hFFFE && n < 70000) begin
            step();
            n++;
        end
        valid_i = 1'b0;
        checks++;
        if (ovf_count_o !== 16'hFFFE) begin
            fails++;
            $display("FAIL sat_fffe: got %h want fffe (iterations %0d)", ovf_count_o, n);
        end
        step();
        valid_i = 1'b1;
        step();
        checks++;
        if (ovf_count_o !== 16'hFFFF) begin
            fails++;
            $display("FAIL sat_ffff: got %h want ffff", ovf_count_o);
        end
        step();
        valid_i = 1'b0;
        step();
        checks++;
        if (ovf_count_o !== 16'hFFFF) begin
            fails++;
            $display("FAIL sat_hold: got %h want ffff", ovf_count_o);
        end
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        drive(1, 33'h0_0000_0055, 0, 0, ADD, 0, 0, 5'd6);
        step();
        valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || ovf_count_o !== 16'd0 || ready_o !== 1'b1 || we_o !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got v=%b cnt=%h rdy=%b we=%b want 0 0 1 0", valid_o, ovf_count_o, ready_o, we_o);
        end
        step();
        rst_n = 1'b1;
        ready_i = 1'b1;
        drive(1, 33'h0_0000_0077, 0, 0, ADD, 0, 0, 5'd8);
        step();
        drive(0, '0, 0, 0, ADD, 0, 0, 5'd0);
        checks++;
        if (valid_o !== 1'b1 || result_o !== 32'h77 || we_o !== 1'b1) begin
            fails++;
            $display("FAIL post_reset: got v=%b res=%h we=%b want 1 77 1", valid_o, result_o, we_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_addu();
        test_sub_and_write();
        test_back_to_back();
        test_flush();
        test_saturate();
        test_async_reset();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/m1_ex_reg.md
M1_EX_REG -- requirements
Module: m1_ex_reg

Interface
REQ-001 Parameter: TRAP_ON_OVF, default 1, 1 = overflowed entries have write-enable suppressed; 0 = overflow flagged only.
REQ-002 sys_clock_i  input  1  single clock; all state updates on rising edge.
REQ-003 sys_reset_i  input  1  asynchronous, active-low reset.
REQ-004 flush_i  input  1  synchronous discard of all held entries and of the same-cycle input.
REQ-005 valid_i  input  1  upstream execute-stage entry valid.
REQ-006 ready_o  output  1  block can accept an entry this cycle.
REQ-007 alu_result_i  input  33  ALU result; bit 32 is carry.
REQ-008 a_msb_i  input  1  bit 31 of ALU operand A.
REQ-009 b_msb_i  input  1  bit 31 of ALU operand B.
REQ-010 func_i  input  5  ALU function code (ALU_OP_* from m1_defs.vh).
REQ-011 signed_i  input  1  operation is signed.
REQ-012 trap_en_i  input  1  instruction traps on overflow (ADD/ADDI/SUB, not ADDU/SUBU).
REQ-013 rd_i  input  5  destination register index.
REQ-014 valid_o  output  1  output entry valid.
REQ-015 ready_i  input  1  downstream accepts output entry.
REQ-016 result_o  output  32  registered result.
REQ-017 carry_o  output  1  registered carry bit.
REQ-018 rd_o  output  5  registered destination index.
REQ-019 we_o  output  1  register-file write enable for the entry.
REQ-020 ovf_o  output  1  entry raised arithmetic overflow exception.
REQ-021 ovf_count_o  output  16  saturating count of accepted overflowed entries.

Function
REQ-022 Storage SHALL be two entries: main (drives outputs) and skid; FIFO order SHALL be preserved.
REQ-023 Input SHALL be accepted on an edge where valid_i=1, ready_o=1, flush_i=0.
REQ-024 ready_o SHALL equal NOT skid_valid, from registered state only (no combinational path from ready_i).
REQ-025 valid_o SHALL equal main_valid; result_o, carry_o, rd_o, we_o, ovf_o SHALL come from main entry registers.
REQ-026 Overflow at capture: ovf=1 only if signed_i=1 and trap_en_i=1 and either func_i=ALU_OP_ADD with a_msb_i==b_msb_i and alu_result_i[31]!=a_msb_i, or func_i=ALU_OP_SUB with a_msb_i!=b_msb_i and alu_result_i[31]!=a_msb_i; otherwise 0.
REQ-027 we at capture SHALL be (rd_i!=0) AND NOT(ovf AND TRAP_ON_OVF).
REQ-028 Output transfer SHALL occur on an edge where valid_o=1 and ready_i=1.
REQ-029 Main empty or transferring, skid empty, input accepted: main <= input; latency 1 cycle from accept to valid_o.
REQ-030 Main full, no transfer, input accepted: skid <= input; ready_o drops next cycle.
REQ-031 Main transferring with skid full: main <= skid, skid cleared; no input accepted that cycle.
REQ-032 Main transferring, skid empty, no input: main_valid <= 0.
REQ-033 flush_i=1: main_valid and skid_valid <= 0 next edge; same-cycle input discarded; ovf_count_o not incremented for it; flush overrides transfer.
REQ-034 ovf_count_o SHALL increment by 1 on each accepted entry with ovf=1, saturating at 16'hFFFF, unaffected by flush_i.
REQ-035 Data registers of invalid entries are don't-care, but we_o and ovf_o SHALL be 0 whenever valid_o=0.

Reset
REQ-036 sys_reset_i=0 SHALL immediately force main_valid=0, skid_valid=0, ready_o=1, valid_o=0, result_o=0, carry_o=0, rd_o=0, we_o=0, ovf_o=0, ovf_count_o=0, regardless of clock.
REQ-037 Reset asserted mid-transfer SHALL drop all held entries; first accept after release SHALL behave as REQ-029.

Verification
REQ-038 ADD signed trap, alu_result_i=33'h0_80000000, a_msb=0, b_msb=0, rd=5, ready_i=1 -> next cycle valid_o=1, ovf_o=1, we_o=0, ovf_count_o=1.
REQ-039 ADDU (trap_en_i=0) same operands, rd=0 -> ovf_o=0, we_o=0 (rd=0), result_o=32'h80000000.
REQ-040 ready_i=0, three back-to-back inputs results 1,2,3 -> 1 in main, 2 in skid, ready_o=0, 3 not accepted; ready_i=1 -> outputs 1 then 2 on consecutive cycles, ready_o=1 after 2 reaches main.
REQ-041 Main and skid full, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, counter unchanged.
REQ-042 Force ovf_count_o to 16'hFFFE via overflowed inputs, two more overflows -> 16'hFFFF, stays 16'hFFFF.
REQ-043 Assert sys_reset_i=0 between clock edges with valid_o=1 -> valid_o=0 and ovf_count_o=0 before next edge.
